// File: rtl/boa_peri_pmu_multi.sv
// rtl/boa_peri_pmu_multi.sv - key-protected PMU: timed system reset, abortable delayed shutdown, per-channel reset pulses
// Optional watchdog at offsets 0x10/0x14 is built when BOA_PMU_WDT_EN is defined.
module boa_peri_pmu_multi #(
  parameter logic [31:0] addr          = 32'h8000_0000,
  parameter int          n_chan        = 4,
  parameter int          hold_cycles   = 16,
  parameter logic [15:0] delay_default = 16'd1000,
  parameter logic [15:0] key           = 16'hB0A5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       bus_addr,
  input  logic [3:0]        bus_we,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_ready,
  output logic              pmb_rst,
  output logic              pmb_shdn,
  output logic [n_chan-1:0] chan_rst
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RST_HOLD  = 2'd1,
    SHDN_WAIT = 2'd2,
    SHDN      = 2'd3
  } state_t;

  localparam logic [15:0] hold = 16'(hold_cycles);

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] delay_q;
  logic [15:0] ch_cnt [n_chan];

  logic [31:0] byte_addr;
  logic        hit;
  logic [2:0]  off;
  logic        wr;
  logic        key_ok;
  logic        ctrl_ok;
  logic        chrst_wr;
  logic        delay_wr;
  logic        wdt_fire;
  logic [31:0] wdt_rdata;
  logic        unused_we;

  assign byte_addr = bus_addr << 2;
  assign hit       = (byte_addr & ~32'h1F) == addr;
  assign off       = bus_addr[2:0];
  assign wr        = hit & bus_we[0];
  assign key_ok    = bus_wdata[31:16] == key;
  assign ctrl_ok   = wr && (off == 3'd0) && key_ok;
  assign chrst_wr  = wr && (off == 3'd2) && (state != RST_HOLD) && (state != SHDN);
  assign delay_wr  = wr && (off == 3'd3) && (state != SHDN);
  assign bus_ready = 1'b1;
  assign unused_we = ^bus_we[3:1];

  // pmb_rst / pmb_shdn are set on the transition edge so they track the state register exactly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pmb_rst  <= 1'b0;
      pmb_shdn <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if ((ctrl_ok && bus_wdata[0]) || wdt_fire) begin
            state   <= RST_HOLD;
            cnt     <= hold;
            pmb_rst <= 1'b1;
          end else if (ctrl_ok && bus_wdata[1]) begin
            state <= SHDN_WAIT;
            cnt   <= delay_q;
          end
        end
        RST_HOLD: begin
          if (cnt <= 16'd1) begin
            state   <= IDLE;
            cnt     <= '0;
            pmb_rst <= 1'b0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        SHDN_WAIT: begin
          if ((ctrl_ok && bus_wdata[0]) || wdt_fire) begin
            state   <= RST_HOLD;
            cnt     <= hold;
            pmb_rst <= 1'b1;
          end else if (ctrl_ok && bus_wdata[2]) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == 16'd0) begin
            state    <= SHDN;
            pmb_shdn <= 1'b1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        SHDN: begin
          pmb_shdn <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      delay_q <= delay_default;
    end else if (delay_wr) begin
      delay_q <= bus_wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < n_chan; i++) ch_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < n_chan; i++) begin
        if (chrst_wr && bus_wdata[i]) begin
          ch_cnt[i] <= hold;
        end else if (ch_cnt[i] != 16'd0) begin
          ch_cnt[i] <= ch_cnt[i] - 16'd1;
        end
      end
    end
  end

  always_comb begin
    chan_rst = '0;
    for (int i = 0; i < n_chan; i++) begin
      chan_rst[i] = (ch_cnt[i] != 16'd0) || (state == RST_HOLD);
    end
  end

`ifdef BOA_PMU_WDT_EN
  logic        wdt_en;
  logic        wdt_cause;
  logic [23:0] wdt_cnt;
  logic [23:0] wdt_load;
  logic        wdt_ctrl_wr;
  logic        wdt_load_wr;
  logic        wdt_run;
  logic        wdt_reload;

  assign wdt_ctrl_wr = wr && (off == 3'd4) && (state != SHDN);
  assign wdt_load_wr = wr && (off == 3'd5) && (state != SHDN);
  assign wdt_run     = wdt_en && ((state == IDLE) || (state == SHDN_WAIT));
  assign wdt_fire    = wdt_run && (wdt_cnt == 24'd0);
  assign wdt_reload  = wdt_ctrl_wr && ((bus_wdata[0] && !wdt_en) || (bus_wdata[1] && key_ok));
  assign wdt_rdata   = (off == 3'd4) ? {29'd0, wdt_cause, 1'b0, wdt_en} : {8'd0, wdt_load};

  // expiry outranks a same-cycle register write so the cause flag cannot be lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdt_en    <= 1'b0;
      wdt_cause <= 1'b0;
      wdt_cnt   <= '0;
      wdt_load  <= 24'hFFFFFF;
    end else begin
      if (wdt_load_wr) wdt_load <= bus_wdata[23:0];
      if (wdt_fire) begin
        wdt_en    <= 1'b0;
        wdt_cause <= 1'b1;
      end else begin
        if (wdt_ctrl_wr) begin
          wdt_en <= bus_wdata[0];
          if (bus_wdata[2]) wdt_cause <= 1'b0;
        end
        if (wdt_reload) begin
          wdt_cnt <= wdt_load;
        end else if (wdt_run) begin
          wdt_cnt <= wdt_cnt - 24'd1;
        end
      end
    end
  end
`else
  assign wdt_fire  = 1'b0;
  assign wdt_rdata = '0;
`endif

  always_comb begin
    bus_rdata = '0;
    if (hit) begin
      case (off)
        3'd1: begin
          bus_rdata[1:0]          = state;
          bus_rdata[16 +: n_chan] = chan_rst;
        end
        3'd3:       bus_rdata[15:0] = delay_q;
        3'd4, 3'd5: bus_rdata       = wdt_rdata;
        default:    bus_rdata       = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_boa_peri_pmu_multi.sv
// tb/tb_boa_peri_pmu_multi.sv - randomized self-checking bench for boa_peri_pmu_multi using a timestamp-window model
module tb_boa_peri_pmu_multi;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_STAT = BASE + 32'h04;
  localparam logic [31:0] A_CHRST = BASE + 32'h08;
  localparam logic [31:0] A_DELAY = BASE + 32'h0C;
  localparam logic [31:0] A_WCTRL = BASE + 32'h10;
  localparam logic [31:0] A_WLOAD = BASE + 32'h14;
  localparam int N = 4;
  localparam int H = 16;
  localparam int INF = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] bus_addr;
  logic [3:0] bus_we;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic bus_ready;
  logic pmb_rst;
  logic pmb_shdn;
  logic [N-1:0] chan_rst;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int wr_edge;
  // model: pmb_rst high for samples in [rst_from, rst_from+H); waiting from wait_from; shut down from shdn_from
  int rst_from;
  int wait_from;
  int shdn_from;
  int chan_end [N];

  boa_peri_pmu_multi dut (
    .clk       (clk),
    .rst       (rst),
    .bus_addr  (bus_addr),
    .bus_we    (bus_we),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .pmb_rst   (pmb_rst),
    .pmb_shdn  (pmb_shdn),
    .chan_rst  (chan_rst)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_clear();
    rst_from = -INF;
    wait_from = INF;
    shdn_from = INF;
    for (int i = 0; i < N; i++) chan_end[i] = 0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    bus_addr = a >> 2;
    bus_wdata = d;
    bus_we = we;
    @(posedge clk);
    #1;
    wr_edge = cyc;
    bus_we = 4'h0;
    bus_wdata = '0;
    bus_addr = A_STAT >> 2;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus_addr = a >> 2;
    bus_we = 4'h0;
    #1;
    d = bus_rdata;
    bus_addr = A_STAT >> 2;
  endtask

  task automatic run_check(input int n);
    int c;
    logic e_rst, e_shdn;
    logic [1:0] e_state;
    logic [N-1:0] e_chan;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      c = cyc;
      e_rst = (c >= rst_from) && (c < rst_from + H);
      e_shdn = (c >= shdn_from);
      e_state = e_rst ? 2'd1 : e_shdn ? 2'd3 : (c >= wait_from) ? 2'd2 : 2'd0;
      for (int i = 0; i < N; i++) e_chan[i] = (c < chan_end[i]) || e_rst;
      n_checks++;
      if (pmb_rst !== e_rst) begin
        n_fail++;
        $display("FAIL pmb_rst cyc=%0d got %b exp %b", c, pmb_rst, e_rst);
      end
      n_checks++;
      if (pmb_shdn !== e_shdn) begin
        n_fail++;
        $display("FAIL pmb_shdn cyc=%0d got %b exp %b", c, pmb_shdn, e_shdn);
      end
      n_checks++;
      if (chan_rst !== e_chan) begin
        n_fail++;
        $display("FAIL chan_rst cyc=%0d got %b exp %b", c, chan_rst, e_chan);
      end
      n_checks++;
      if (bus_rdata[1:0] !== e_state || bus_rdata[16 +: N] !== e_chan) begin
        n_fail++;
        $display("FAIL status cyc=%0d got %h exp state %0d chan %b", c, bus_rdata, e_state, e_chan);
      end
    end
  endtask

  task automatic do_reset();
    logic [31:0] d;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (pmb_rst !== 1'b0 || pmb_shdn !== 1'b0 || chan_rst !== '0) begin
      n_fail++;
      $display("FAIL async_reset outputs got rst=%b shdn=%b chan=%b exp all 0", pmb_rst, pmb_shdn, chan_rst);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    bus_read(A_DELAY, d);
    n_checks++;
    if (d !== 32'd1000) begin
      n_fail++;
      $display("FAIL delay_after_reset got %0d exp 1000", d);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bus_addr = A_STAT >> 2;
    bus_we = 4'h0;
    bus_wdata = '0;
    model_clear();
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    n_checks++;
    if (pmb_rst !== 1'b0 || pmb_shdn !== 1'b0 || chan_rst !== '0 || bus_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_outputs got rst=%b shdn=%b chan=%b ready=%b", pmb_rst, pmb_shdn, chan_rst, bus_ready);
    end
    bus_read(A_STAT, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_status got %h exp 0", d); end
    bus_read(A_DELAY, d);
    n_checks++;
    if (d !== 32'd1000) begin n_fail++; $display("FAIL reset_delay got %0d exp 1000", d); end
    bus_read(A_CTRL, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL ctrl_read got %h exp 0", d); end
    run_check(2);
  endtask

  task automatic test_sys_reset();
    bus_write(A_CTRL, 32'hB0A5_0001, 4'h1);
    rst_from = wr_edge;
    run_check(H + 4);
  endtask

  task automatic test_bad_key();
    logic [15:0] k;
    bus_write(A_CTRL, 32'h1234_0003, 4'h1);
    run_check(4);
    for (int it = 0; it < 6; it++) begin
      k = 16'($urandom_range(0, 16'hFFFF));
      if (k == 16'hB0A5) k = 16'h1234;
      bus_write(A_CTRL, {k, 13'd0, 3'($urandom_range(1, 7))}, 4'h1);
      run_check(3);
    end
    bus_write(A_CTRL, 32'hB0A5_0001, 4'b1110);
    run_check(3);
    bus_write(BASE + 32'h20, 32'hB0A5_0001, 4'h1);
    run_check(3);
  endtask

  task automatic test_delay_rw();
    logic [31:0] d;
    logic [15:0] v;
    for (int it = 0; it < 3; it++) begin
      v = 16'($urandom_range(0, 16'hFFFF));
      bus_write(A_DELAY, {16'hFFFF, v}, 4'h1);
      bus_read(A_DELAY, d);
      n_checks++;
      if (d !== {16'd0, v}) begin n_fail++; $display("FAIL delay_rw got %h exp %h", d, v); end
    end
    bus_read(A_CHRST, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL chrst_read got %h exp 0", d); end
    bus_read(BASE + 32'h2C, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL miss_read got %h exp 0", d); end
  endtask

  task automatic test_shutdown(input int dl);
    bus_write(A_DELAY, dl, 4'h1);
    bus_write(A_CTRL, 32'hB0A5_0002, 4'h1);
    wait_from = wr_edge;
    shdn_from = wr_edge + dl + 1;
    run_check(2);
    bus_write(A_DELAY, 32'($urandom_range(0, 3)), 4'h1);
    run_check(dl + 4);
    bus_write(A_CTRL, 32'hB0A5_0001, 4'h1);
    run_check(2);
    bus_write(A_CHRST, 32'hF, 4'h1);
    run_check(3);
    do_reset();
  endtask

  task automatic test_abort();
    int dl;
    dl = $urandom_range(6, 20);
    bus_write(A_DELAY, dl, 4'h1);
    bus_write(A_CTRL, 32'hB0A5_0002, 4'h1);
    wait_from = wr_edge;
    shdn_from = wr_edge + dl + 1;
    run_check(3);
    bus_write(A_CTRL, 32'hB0A5_0004, 4'h1);
    wait_from = INF;
    shdn_from = INF;
    run_check(dl + 5);
  endtask

  task automatic test_reset_priority();
    bus_write(A_CTRL, 32'hB0A5_0003, 4'h1);
    rst_from = wr_edge;
    run_check(H + 3);
    bus_write(A_DELAY, 20, 4'h1);
    bus_write(A_CTRL, 32'hB0A5_0002, 4'h1);
    wait_from = wr_edge;
    shdn_from = wr_edge + 21;
    run_check(4);
    bus_write(A_CTRL, 32'hB0A5_0001, 4'h1);
    rst_from = wr_edge;
    wait_from = INF;
    shdn_from = INF;
    run_check(H + 25);
  endtask

  task automatic test_chrst();
    int m;
    bus_write(A_CHRST, 32'h5, 4'h1);
    chan_end[0] = wr_edge + H;
    chan_end[2] = wr_edge + H;
    run_check(10);
    bus_write(A_CHRST, 32'h1, 4'h1);
    chan_end[0] = wr_edge + H;
    run_check(H + 4);
    for (int it = 0; it < 4; it++) begin
      m = $urandom_range(0, 15);
      bus_write(A_CHRST, m, 4'h1);
      for (int i = 0; i < N; i++) if (m[i]) chan_end[i] = wr_edge + H;
      run_check($urandom_range(1, 20));
    end
    bus_write(A_CTRL, 32'hB0A5_0001, 4'h1);
    rst_from = wr_edge;
    run_check(3);
    bus_write(A_CHRST, 32'hF, 4'h1);
    bus_write(A_CTRL, 32'hB0A5_0002, 4'h1);
    run_check(H + 3);
  endtask

  task automatic test_async_reset();
    bus_write(A_DELAY, 50, 4'h1);
    bus_write(A_CTRL, 32'hB0A5_0002, 4'h1);
    wait_from = wr_edge;
    shdn_from = wr_edge + 51;
    run_check(5);
    do_reset();
    run_check(3);
    bus_write(A_CHRST, 32'hF, 4'h1);
    for (int i = 0; i < N; i++) chan_end[i] = wr_edge + H;
    bus_write(A_CTRL, 32'hB0A5_0001, 4'h1);
    rst_from = wr_edge;
    run_check(5);
    do_reset();
    run_check(3);
  endtask

`ifdef BOA_PMU_WDT_EN
  task automatic test_wdt();
    logic [31:0] d;
    int l;
    bus_write(A_WLOAD, 32'd100, 4'h1);
    bus_read(A_WLOAD, d);
    n_checks++;
    if (d !== 32'd100) begin n_fail++; $display("FAIL wdt_load got %0d exp 100", d); end
    bus_write(A_WCTRL, 32'h1, 4'h1);
    rst_from = wr_edge + 101;
    run_check(101 + H + 4);
    bus_read(A_WCTRL, d);
    n_checks++;
    if (d !== 32'h4) begin n_fail++; $display("FAIL wdt_cause got %h exp 4", d); end
    bus_write(A_WCTRL, 32'h4, 4'h1);
    bus_read(A_WCTRL, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL wdt_w1c got %h exp 0", d); end
    l = $urandom_range(20, 60);
    bus_write(A_WLOAD, l, 4'h1);
    bus_write(A_WCTRL, 32'h1, 4'h1);
    run_check(10);
    bus_write(A_WCTRL, 32'hB0A5_0003, 4'h1);
    rst_from = wr_edge + l + 1;
    run_check(l + H + 5);
    bus_read(A_WCTRL, d);
    n_checks++;
    if (d !== 32'h4) begin n_fail++; $display("FAIL wdt_kick_cause got %h exp 4", d); end
  endtask
`else
  task automatic test_wdt();
    logic [31:0] d;
    bus_write(A_WCTRL, 32'hB0A5_0003, 4'h1);
    bus_write(A_WLOAD, 32'd5, 4'h1);
    bus_read(A_WCTRL, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL wdt_ctrl_absent got %h exp 0", d); end
    bus_read(A_WLOAD, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL wdt_load_absent got %h exp 0", d); end
    run_check(10);
  endtask
`endif

  initial begin
    test_reset();
    test_sys_reset();
    test_bad_key();
    test_delay_rw();
    test_shutdown(5);
    test_shutdown(0);
    test_shutdown($urandom_range(1, 30));
    test_abort();
    test_reset_priority();
    test_chrst();
    test_async_reset();
    test_wdt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/boa_peri_pmu_multi.md
Name: boa_peri_pmu_multi

Overview:
- Memory-mapped power management unit: second-generation successor of the single-register PMU.
- Adds key-protected control, timed system-reset pulse, delayed and abortable shutdown, and N independently pulsed peripheral reset channels, with status readback.
- Sits on the peripheral bus as a boa_mem_bus.MEM slave; drives pmu_bus.CPU (rst, shdn) and a per-channel reset vector.

Parameters:
- addr, 32'h8000_0000, base byte address; must be 32-byte aligned; window is 8 words.
- n_chan, 4, number of peripheral reset channels, 1..16.
- hold_cycles, 16, cycles pmb.rst / chan_rst[i] stay asserted per pulse, 1..65535.
- delay_default, 16'd1000, reset value of DELAY register.
- key, 16'hB0A5, required value in wdata[31:16] for CTRL writes.

Ports:
- clk  in  1  CPU clock.
- rst  in  1  asynchronous active-low reset.
- bus  boa_mem_bus.MEM  -  uses addr (word address), we[3:0], wdata[31:0], rdata[31:0], ready.
- pmb  pmu_bus.CPU  -  rst (system reset request), shdn (system shutdown).
- chan_rst  out  n_chan  per-channel peripheral reset, active-high.

Behaviour:
- Decode: hit when ((bus.addr<<2) & ~32'h1F) == addr. Write happens when we[0]; other byte lanes are ignored. bus.ready is constant 1. rdata is combinational from the addressed word; misses and unused offsets read 0.
- Writes take effect at the next rising clk edge.
- Registers (byte offset):
  - 0x00 CTRL, write-only, reads 0. Accepted only if wdata[31:16]==key; otherwise ignored. Bit0 = reset request, bit1 = shutdown request, bit2 = abort.
  - 0x04 STATUS, RO: [1:0] state (0 IDLE, 1 RST_HOLD, 2 SHDN_WAIT, 3 SHDN); [16+:n_chan] live chan_rst.
  - 0x08 CHRST, W: each 1 bit in [n_chan-1:0] loads that channel's counter with hold_cycles. Reads 0.
  - 0x0C DELAY, RW [15:0]; reset value delay_default.
- FSM reset value: IDLE. Async reset sets all outputs 0, all counters 0, DELAY=delay_default.
- IDLE:
  - accepted CTRL bit0 -> RST_HOLD, counter=hold_cycles.
  - else bit1 -> SHDN_WAIT, counter=DELAY.
  - bit0 and bit1 together: reset wins.
- RST_HOLD:
  - pmb.rst=1 and all chan_rst=1.
  - Counter decrements each cycle; at 1 -> IDLE.
  - pmb.rst is high for exactly hold_cycles cycles, starting the cycle after the write.
  - All CTRL and CHRST writes are ignored.
- SHDN_WAIT:
  - counter==0 -> SHDN; else decrement. DELAY=0 gives SHDN one cycle after entry.
  - Accepted CTRL bit0 -> RST_HOLD (priority). Bit2 -> IDLE. Bit1 is ignored (no restart).
  - DELAY writes do not affect the running countdown.
- SHDN:
  - pmb.shdn=1; terminal until rst; all writes ignored.
  - pmb.rst is not asserted.
- Channel counters:
  - 16-bit each, saturate at 0.
  - chan_rst[i] = (cnt[i]!=0) | (state==RST_HOLD).
  - A CHRST write to an active channel reloads it (extends the pulse).
- pmb.rst and pmb.shdn are registered outputs (state-decoded flops); never both high.

Optional Feature:
- Macro BOA_PMU_WDT_EN adds a watchdog.
- With the macro:
  - 0x10 WDT_CTRL: bit0 enable (RW). Bit1 kick (W), needs key in [31:16]. Bit2 cause flag (RO, W1C).
  - 0x14 WDT_LOAD: RW 24-bit reload value, reset value 24'hFFFFFF.
  - While enabled in IDLE or SHDN_WAIT, the counter decrements each cycle.
  - Kick or enable 0->1 reloads WDT_LOAD.
  - Reaching 0 -> RST_HOLD, sets cause flag, clears enable.
  - Watchdog is frozen in RST_HOLD and SHDN.
- Without the macro: 0x10 and 0x14 read 0, writes are ignored, no watchdog logic.

Test Plan:
- Write CTRL 32'hB0A5_0001 -> pmb.rst high exactly 16 cycles starting next cycle; all chan_rst high; STATUS[1:0]=1 then 0.
- Write CTRL 32'h1234_0003 (bad key) -> no state change, pmb.rst/shdn stay 0.
- DELAY=5, CTRL 32'hB0A5_0002 -> pmb.shdn rises 6 cycles after the write edge and stays high. Repeat with abort 32'hB0A5_0004 at cycle 3 -> returns IDLE, shdn never asserted.
- CTRL 32'hB0A5_0003 -> RST_HOLD chosen, shdn never asserted. During SHDN_WAIT, 32'hB0A5_0001 -> RST_HOLD.
- CHRST 4'b0101, then rewrite bit0 after 10 cycles -> chan_rst[2] high 16 cycles, chan_rst[0] high 26 cycles, chan_rst[1,3] low.
- Assert rst low mid-SHDN_WAIT and mid-RST_HOLD -> all outputs 0 immediately (async). DELAY reads 1000 after release. With BOA_PMU_WDT_EN: WDT_LOAD=100, enable, no kick -> RST_HOLD after 101 cycles, cause flag=1.
